// File: rtl/modulo_arbitro_mux4_pkg.sv
// modulo_arbitro_mux4_pkg
// Shared definitions for the 4-way round-robin arbiter that drives a 4:1 mux:
//   N_REQ      number of requesters
//   HOLD_W     width of the consecutive-grant hold counter
//   state_t    arbiter FSM state encoding (IDLE / GRANT)
//   idx_to_sel maps a granted index to the mux select code
package modulo_arbitro_mux4_pkg;

    localparam int N_REQ  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The downstream mux presents input_e[3] at select 00 and input_e[0] at
    // select 11, so the select code is the bitwise inverse of the index.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/modulo_arbitro_mux4_rr_pick.sv
// modulo_rr_pick
// Combinational round-robin winner search. The search starts one past the
// last granted index and ascends modulo 4; the first requester that is high
// and not masked out wins.
// Ports:
//   i_req   [3:0]  sampled request levels
//   i_last  [1:0]  last granted index
//   i_excl  [3:0]  requesters to skip (the current owner when rotating away)
//   o_found        a winner exists
//   o_idx   [1:0]  winner index (valid when o_found)
module modulo_rr_pick
    import modulo_arbitro_mux4_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_last,
    input  logic [N_REQ-1:0] i_excl,
    output logic             o_found,
    output logic [1:0]       o_idx
);

    logic [N_REQ-1:0] w_elig;
    logic [1:0]       w_cand;

    assign w_elig = i_req & ~i_excl;

    always_comb begin
        o_found = 1'b0;
        o_idx   = 2'd0;
        w_cand  = 2'd0;
        // Offsets 1..4: offset 4 wraps back to i_last itself, checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = i_last + 2'(k);
            if (!o_found && w_elig[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/modulo_arbitro_mux4.sv
// modulo_arbitro_mux4
// Round-robin arbiter for four requesters with a bounded hold time, driving
// the select of a 4:1 mux. All outputs come straight from flops.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req  [3:0] level-sensitive requests, bit i from requester i
//   gnt  [3:0] one-hot grant, zero when idle
//   sel  [1:0] mux select, inverse of the last granted index; held while idle
//   busy       high whenever gnt is non-zero
//   preempt    one-cycle pulse when a grant is forcibly rotated
//   dbg_state  current FSM state
// Handshake: req is a level; a requester owns the mux from the cycle gnt
// shows its bit until the cycle after it drops req (or is preempted after
// MAX_HOLD consecutive cycles while someone else is waiting).
module modulo_arbitro_mux4
    import modulo_arbitro_mux4_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             preempt,
    output state_t           dbg_state
);

    localparam logic [HOLD_W-1:0] C_MAX = HOLD_W'(MAX_HOLD);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_preempt;
    logic [1:0]       r_last;
    logic [HOLD_W-1:0] r_cnt;

    logic [N_REQ-1:0] w_excl;
    logic             w_found;
    logic [1:0]       w_win;
    logic             w_take;
    logic             w_drop;
    logic             w_pre;

    // While granting, the owner is excluded so that w_found means
    // "somebody else is waiting".
    assign w_excl = (r_state == ST_GRANT) ? (4'b0001 << r_last) : 4'b0000;

    modulo_rr_pick u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .i_excl  (w_excl),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    always_comb begin
        w_take = 1'b0;
        w_drop = 1'b0;
        w_pre  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_take = w_found;
            end
            ST_GRANT: begin
                if (!req[r_last]) begin
                    w_take = w_found;
                    w_drop = !w_found;
                end else if (r_cnt == C_MAX) begin
                    w_take = w_found;
                    w_pre  = w_found;
                end
            end
            default: begin
                w_drop = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_sel     <= 2'b00;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_last    <= 2'd3;
            r_cnt     <= '0;
        end else begin
            r_preempt <= w_pre;
            if (w_take) begin
                r_state <= ST_GRANT;
                r_gnt   <= 4'b0001 << w_win;
                r_sel   <= idx_to_sel(w_win);
                r_busy  <= 1'b1;
                r_last  <= w_win;
                r_cnt   <= HOLD_W'(1);
            end else if (w_drop) begin
                // sel and r_last are kept so the next search resumes after
                // the previous owner.
                r_state <= ST_IDLE;
                r_gnt   <= '0;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == ST_GRANT && r_cnt != C_MAX) begin
                r_cnt <= r_cnt + HOLD_W'(1);
            end
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign preempt   = r_preempt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_modulo_arbitro_mux4.sv
module tb_modulo_arbitro_mux4;
  import modulo_arbitro_mux4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = 4'b0000;
  always #5 clk = ~clk;

  logic [3:0] gnt8, gnt1;
  logic [1:0] sel8, sel1;
  logic       busy8, busy1, pre8, pre1;
  state_t     st8, st1;

  modulo_arbitro_mux4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt8), .sel(sel8),
    .busy(busy8), .preempt(pre8), .dbg_state(st8)
  );

  modulo_arbitro_mux4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .sel(sel1),
    .busy(busy1), .preempt(pre1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // owner = -1 means nobody holds the mux.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];
  int m_pre[2];
  int m_sel[2];

  function automatic int rr_winner(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic give_to(input int k, input int w);
    m_owner[k] = w;
    m_last[k]  = w;
    m_cnt[k]   = 1;
    m_sel[k]   = 3 - w;
  endtask

  task automatic step_model(input int k, input int hold, input logic [3:0] r, input logic rst);
    int w;
    if (rst) begin
      m_owner[k] = -1; m_last[k] = 3; m_cnt[k] = 0; m_pre[k] = 0; m_sel[k] = 0;
      return;
    end
    m_pre[k] = 0;
    if (m_owner[k] < 0) begin
      w = rr_winner(r, m_last[k], -1);
      if (w >= 0) give_to(k, w);
    end else begin
      w = rr_winner(r, m_last[k], m_owner[k]);
      if (!r[m_owner[k]]) begin
        if (w >= 0) give_to(k, w);
        else begin m_owner[k] = -1; m_cnt[k] = 0; end
      end else if (m_cnt[k] >= hold && w >= 0) begin
        give_to(k, w);
        m_pre[k] = 1;
      end else if (m_cnt[k] < hold) begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic compare_one(input string name, input int k, input logic [3:0] g,
                             input logic [1:0] s, input logic b, input logic p, input state_t st);
    logic [3:0] eg;
    eg = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
    check_eq({name, "_gnt"},     8'(g),  8'(eg));
    check_eq({name, "_sel"},     8'(s),  8'(m_sel[k]));
    check_eq({name, "_busy"},    8'(b),  8'(m_owner[k] >= 0));
    check_eq({name, "_preempt"}, 8'(p),  8'(m_pre[k]));
    check_eq({name, "_state"},   8'(st), 8'((m_owner[k] >= 0) ? ST_GRANT : ST_IDLE));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] r, input logic rst);
    req   = r;
    reset = rst;
    @(posedge clk);
    step_model(0, 8, r, rst);
    step_model(1, 1, r, rst);
    #1;
    compare_one("h8", 0, gnt8, sel8, busy8, pre8, st8);
    compare_one("h1", 1, gnt1, sel1, busy1, pre1, st1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_seq [5];
    logic [3:0] r;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

    // reset values
    cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    check_eq("rst_sel", 8'(sel8), 8'h00);

    // first grant after reset goes to index 0
    cycle(4'b1111, 1'b0);
    check_eq("first_gnt", 8'(gnt8), 8'h01);
    check_eq("first_sel", 8'(sel8), 8'h03);
    repeat (3) cycle(4'b0000, 1'b0);

    // two requesters with hold limit
    cycle(4'b0000, 1'b1);
    repeat (20) cycle(4'b0101, 1'b0);

    // lone requester never preempted
    repeat (20) cycle(4'b0100, 1'b0);

    // owner drops while another waits, then all drop
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b0);
    cycle(4'b1000, 1'b0);
    check_eq("handoff_gnt", 8'(gnt8), 8'h08);
    cycle(4'b0000, 1'b0);
    check_eq("idle_sel", 8'(sel8), 8'h00);

    // reset in mid-grant
    repeat (3) cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    check_eq("midrst_gnt", 8'(gnt8), 8'h00);
    cycle(4'b0010, 1'b0);
    check_eq("postrst_gnt", 8'(gnt8), 8'h02);

    // MAX_HOLD=1 rotation
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0);
      check_eq("rot_gnt", 8'(gnt1), 8'(exp_seq[i]));
    end

    // randomized traffic; requests tend to persist so holds and preemption occur
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r, ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
